// File: rtl/scan_static_pkg.sv
// Shared types and frame-layout helpers for the scan-to-static-bus bridge.
// Frame layout, MSB first: {scan_id, cmd[1:0], addr, data}.
package scan_static_pkg;

    localparam int DEF_ADDR_W  = 20;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + 2 + addr_w + data_w;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cmd_lsb(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

    localparam int DEF_FRAME_W  = frame_w(DEF_ADDR_W, DEF_DATA_W);
    localparam int DEF_ADDR_LSB = addr_lsb(DEF_DATA_W);
    localparam int DEF_CMD_LSB  = cmd_lsb(DEF_ADDR_W, DEF_DATA_W);
    localparam int DEF_ID_BIT   = DEF_FRAME_W - 1;

endpackage

// File: rtl/scan_static_bridge_shift_reg.sv
// Scan frame register: serial shift toward bit 0, with a parallel load that
// takes priority (status and capture write-back).
module scan_shift_reg #(
    parameter int W = 55
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         shift_in,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] sr
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = load_val;
        end else if (shift_en) begin
            sr_d = {shift_in, sr_q[W-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/scan_static_bridge.sv
// Turns one shifted-in scan frame into a single static-bus read or write and
// writes the result/status back into the frame for serial readout.
module scan_static_bridge
    import scan_static_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_in,
    input  logic              scan_en,
    input  logic              scan_update,
    output logic              scan_out,
    output logic              busy,
    output logic              static_wen,
    output logic              static_ren,
    output logic [ADDR_W-1:0] static_addr,
    output logic [DATA_W-1:0] static_wdata,
    output logic              scan_id,
    input  logic [DATA_W-1:0] static_rdata,
    input  logic              static_ready
);

    localparam int FRAME_W  = frame_w(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int CMD_LSB  = cmd_lsb(ADDR_W, DATA_W);
    localparam int CNT_W    = $clog2(TIMEOUT + 1);

    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] load_val;
    logic               load_en;
    logic               shift_en;
    cmd_e               frame_cmd;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    assign frame_cmd = cmd_e'(sr[CMD_LSB +: 2]);
    assign shift_en  = (state_q == ST_IDLE) && scan_en && !scan_update;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        ren_d     = ren_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        id_d      = id_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        load_en   = 1'b0;
        load_val  = sr;

        case (state_q)
            ST_IDLE: begin
                if (scan_update) begin
                    if (frame_cmd == CMD_WRITE || frame_cmd == CMD_READ) begin
                        state_d   = ST_REQ;
                        wen_d     = (frame_cmd == CMD_WRITE);
                        ren_d     = (frame_cmd == CMD_READ);
                        addr_d    = sr[ADDR_LSB +: ADDR_W];
                        wdata_d   = sr[DATA_W-1:0];
                        id_d      = sr[FRAME_W-1];
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        overrun_d = 1'b0;
                        // Write echoes its data; a read overwrites this on ready, else 0 stays.
                        result_d  = (frame_cmd == CMD_WRITE) ? sr[DATA_W-1:0] : '0;
                    end else begin
                        load_en               = 1'b1;
                        load_val[CMD_LSB +: 2] = 2'b01;
                    end
                end
            end
            ST_REQ: begin
                if (scan_en) overrun_d = 1'b1;
                if (static_ready) begin
                    if (ren_q) result_d = static_rdata;
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        wen_d     = 1'b0;
                        ren_d     = 1'b0;
                        state_d   = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (scan_en) overrun_d = 1'b1;
                load_en  = 1'b1;
                load_val = {id_q, timeout_q | overrun_d, ~timeout_q, addr_q, result_q};
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wen_d   = 1'b0;
                ren_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            id_q      <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            id_q      <= id_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    scan_shift_reg #(.W(FRAME_W)) u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .shift_in (scan_in),
        .load_en  (load_en),
        .load_val (load_val),
        .sr       (sr)
    );

    assign scan_out     = sr[0];
    assign busy         = (state_q != ST_IDLE);
    assign static_wen   = wen_q;
    assign static_ren   = ren_q;
    assign static_addr  = addr_q;
    assign static_wdata = wdata_q;
    assign scan_id      = id_q;

endmodule

// File: tb/tb_scan_static_bridge.sv
// Self-checking bench: directed scan transactions followed by random ones,
// each predicted from the frame rules (request length, status, readout).
module tb_scan_static_bridge;
    import scan_static_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int FW = 1 + 2 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_in = 1'b0;
    logic          scan_en = 1'b0;
    logic          scan_update = 1'b0;
    logic          scan_out;
    logic          busy;
    logic          static_wen;
    logic          static_ren;
    logic [AW-1:0] static_addr;
    logic [DW-1:0] static_wdata;
    logic          scan_id;
    logic [DW-1:0] static_rdata = '0;
    logic          static_ready = 1'b0;

    int            errors = 0;
    int            checks = 0;
    logic [FW-1:0] exp_sr;

    scan_static_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_in      (scan_in),
        .scan_en      (scan_en),
        .scan_update  (scan_update),
        .scan_out     (scan_out),
        .busy         (busy),
        .static_wen   (static_wen),
        .static_ren   (static_ren),
        .static_addr  (static_addr),
        .static_wdata (static_wdata),
        .scan_id      (scan_id),
        .static_rdata (static_rdata),
        .static_ready (static_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift a new frame in while reading the previous register contents out.
    task automatic shift_frame(input logic [FW-1:0] f);
        logic [FW-1:0] got;
        for (int i = 0; i < FW; i++) begin
            got[i]  = scan_out;
            scan_in = f[i];
            scan_en = 1'b1;
            @(negedge clk);
        end
        scan_en = 1'b0;
        check("readout", 64'(got), 64'(exp_sr));
        exp_sr = f;
    endtask

    task automatic run_txn(input logic id, input logic [1:0] cmd, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd,
                           input int delay, input bit ovr);
        logic [FW-1:0] f;
        int            k;
        int            exp_k;
        bit            to;
        f = {id, cmd, a, d};
        shift_frame(f);
        static_rdata = rd;
        static_ready = (delay == 0);
        scan_update  = 1'b1;
        @(negedge clk);
        scan_update  = 1'b0;
        if (cmd != 2'b01 && cmd != 2'b10) begin
            static_ready = 1'b0;
            repeat (3) begin
                check("nop_quiet", {busy, static_wen, static_ren}, 0);
                @(negedge clk);
            end
            exp_sr = {id, 2'b01, f[AW+DW-1:0]};
        end else begin
            check("req_kind", {static_wen, static_ren}, (cmd == 2'b01) ? 2'b10 : 2'b01);
            check("req_addr", static_addr, a);
            check("req_wdata", static_wdata, d);
            check("req_id", scan_id, id);
            k = 0;
            while ((static_wen || static_ren) && k < 50) begin
                check("req_busy", busy, 1);
                check("sr_hold", scan_out, f[0]);
                static_ready = (k >= delay);
                if (ovr && k == 0) begin
                    scan_en = 1'b1;
                    scan_in = ~f[0];
                end
                k++;
                @(negedge clk);
                scan_en = 1'b0;
            end
            static_ready = 1'b0;
            to    = (delay >= TO);
            exp_k = to ? TO : delay + 1;
            check("req_cycles", k, exp_k);
            check("capture_busy", busy, 1);
            @(negedge clk);
            check("idle_busy", {busy, static_wen, static_ren}, 0);
            exp_sr = {id, to | ovr, ~to, a, (cmd == 2'b01) ? d : (to ? '0 : rd)};
        end
    endtask

    initial begin
        logic [FW-1:0] f;
        exp_sr = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {busy, static_wen, static_ren, scan_id, scan_out}, 0);
        check("rst_addr", static_addr, 0);
        check("rst_wdata", static_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 2'b01, 20'h40010, 32'hDEADBEEF, 32'h0, 3, 1'b0);
        run_txn(1'b0, 2'b10, 20'hC0000, 32'h0BADF00D, 32'h12345678, 0, 1'b0);
        run_txn(1'b1, 2'b10, 20'h80004, 32'h11111111, 32'hFFFFFFFF, 99, 1'b0);
        run_txn(1'b0, 2'b00, 20'h00001, 32'hCAFEF00D, 32'h0, 0, 1'b0);
        run_txn(1'b1, 2'b11, 20'h3FFFF, 32'h55AA55AA, 32'h0, 0, 1'b0);
        run_txn(1'b0, 2'b01, 20'h12345, 32'hA5A5A5A5, 32'h0, 2, 1'b1);
        run_txn(1'b1, 2'b01, 20'h54321, 32'h5A5A5A5A, 32'h0, 1, 1'b0);

        // Reset in the middle of a pending write.
        f = {1'b1, 2'b01, 20'h0ABCD, 32'h01234567};
        shift_frame(f);
        scan_update = 1'b1;
        @(negedge clk);
        scan_update = 1'b0;
        @(negedge clk);
        check("pre_rst_wen", static_wen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {busy, static_wen, static_ren, scan_id, scan_out}, 0);
        check("async_rst_bus", {static_addr, static_wdata}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_sr = '0;
        @(negedge clk);
        run_txn(1'b0, 2'b01, 20'h0F00F, 32'h87654321, 32'h0, 1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 20'($urandom),
                    $urandom, $urandom, int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
        end
        shift_frame('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
